// File: rtl/letc_core_pkg.sv
// Shared DMSS port types and small elaboration helpers for the LETC core memory path.
package letc_core_pkg;

  localparam int unsigned DmssAddrW = 32;
  localparam int unsigned DmssDataW = 32;
  localparam int unsigned DmssStrbW = DmssDataW / 8;

  typedef struct packed {
    logic [DmssAddrW-1:0] addr;
    logic                 we;
    logic [DmssDataW-1:0] wdata;
    logic [DmssStrbW-1:0] wstrb;
  } dmss_req_s;

  typedef struct packed {
    logic [DmssDataW-1:0] rdata;
    logic                 err;
  } dmss_rsp_s;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/letc_core_dmss_id_fifo.sv
// In-order FIFO of requester IDs for issued-but-unanswered DMSS requests.
module letc_core_dmss_id_fifo
  import letc_core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = idx_w(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/letc_core_dmss_port_arbiter.sv
// Shares the DMSS data port between requesters: fixed priority with starvation promotion,
// grant lock across stalled handshakes, and in-order response routing.
module letc_core_dmss_port_arbiter
  import letc_core_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_W          = DmssAddrW,
  parameter int unsigned DATA_W          = DmssDataW,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic                          mem_req_we,
  output logic [DATA_W-1:0]             mem_req_wdata,
  output logic [DATA_W/8-1:0]           mem_req_wstrb,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_rdata,
  input  logic                          mem_rsp_err,
  output logic                          proto_err
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned IdxW  = idx_w(NUM_REQ);
  localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);

  logic [IdxW-1:0] gnt;
  logic            promoted;
  logic            issue_blocked, handshake, rsp_pop;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] fifo_head;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            proto_err_q, proto_err_d;
  logic [StW-1:0]  starve_q [NUM_REQ];
  logic [StW-1:0]  starve_d [NUM_REQ];

  // Promotion beats plain priority; an active lock beats both.
  always_comb begin
    gnt      = '0;
    promoted = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i] && (starve_q[i] == StW'(STARVE_LIMIT))) begin
        gnt      = IdxW'(i);
        promoted = 1'b1;
      end
    end
    if (!promoted) begin
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        if (req_valid[i]) gnt = IdxW'(i);
      end
    end
    if (lock_q) gnt = lock_idx_q;
  end

  // Full is taken from registered state, so a same-cycle response cannot free a slot.
  assign issue_blocked = !rst_n || fifo_full;
  assign mem_req_valid = (|req_valid) && !issue_blocked;
  assign handshake     = mem_req_valid && mem_req_ready;
  assign req_ready     = handshake ? (NUM_REQ'(1) << gnt) : '0;

  assign mem_req_addr  = req_addr[gnt * ADDR_W +: ADDR_W];
  assign mem_req_we    = req_we[gnt];
  assign mem_req_wdata = req_wdata[gnt * DATA_W +: DATA_W];
  assign mem_req_wstrb = req_wstrb[gnt * StrbW +: StrbW];

  always_comb begin
    lock_d     = mem_req_valid && !mem_req_ready;
    lock_idx_d = lock_d ? gnt : lock_idx_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && !req_ready[i]) begin
        starve_d[i] = (starve_q[i] == StW'(STARVE_LIMIT)) ? starve_q[i] : starve_q[i] + 1'b1;
      end else begin
        starve_d[i] = '0;
      end
    end
  end

  assign rsp_pop     = mem_rsp_valid && !fifo_empty;
  assign rsp_valid   = (rst_n && rsp_pop) ? (NUM_REQ'(1) << fifo_head) : '0;
  assign rsp_rdata   = mem_rsp_rdata;
  assign rsp_err     = mem_rsp_err;
  assign proto_err_d = proto_err_q || (mem_rsp_valid && fifo_empty);
  assign proto_err   = proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) starve_q[i] <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      proto_err_q <= proto_err_d;
      for (int i = 0; i < int'(NUM_REQ); i++) starve_q[i] <= starve_d[i];
    end
  end

  letc_core_dmss_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdxW)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake),
    .wdata (gnt),
    .pop   (rsp_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  lock_hold_chk: assert property (@(posedge clk) disable iff (!rst_n)
    lock_q |-> req_valid[lock_idx_q]);

endmodule

// File: tb/tb_letc_core_dmss_port_arbiter.sv
// Scoreboard bench: stimulus queues expected issues/responses, a negedge monitor checks them.
module tb_letc_core_dmss_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata, mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]  mem_req_wstrb;
  logic        rsp_err, mem_req_valid, mem_req_ready, mem_req_we;
  logic        mem_rsp_valid, mem_rsp_err, proto_err;

  letc_core_dmss_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_iss(input logic [1:0] sel, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata);
    iss_t e;
    e.sel = sel; e.addr = addr; e.we = we; e.wdata = wdata;
    iss_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [1:0] sel, input logic [31:0] data, input logic err);
    rsp_t e;
    e.sel = sel; e.data = data; e.err = err;
    rsp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata);
    req_addr[i*32 +: 32]  = addr;
    req_we[i]             = we;
    req_wdata[i*32 +: 32] = wdata;
  endtask

  // Monitor: every handshake and every routed response must match the head of its queue.
  initial begin
    iss_t ei;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 64'(iss_q.size()), 64'd1);
        end else begin
          ei = iss_q.pop_front();
          check("issue_sel", 64'(req_ready), 64'(ei.sel));
          check("issue_addr", 64'(mem_req_addr), 64'(ei.addr));
          check("issue_we", 64'(mem_req_we), 64'(ei.we));
          check("issue_wdata", 64'(mem_req_wdata), 64'(ei.wdata));
        end
      end
      if (rsp_valid != 2'b00) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_q.size()), 64'd1);
        end else begin
          er = rsp_q.pop_front();
          check("rsp_sel", 64'(rsp_valid), 64'(er.sel));
          check("rsp_data", 64'(rsp_rdata), 64'(er.data));
          check("rsp_err", 64'(rsp_err), 64'(er.err));
        end
      end
    end
  end

  initial begin
    int gexp [6] = '{0, 0, 0, 0, 1, 0};

    // Reset held with both requesters asserting.
    rst_n         = 1'b0;
    req_valid     = 2'b11;
    req_addr      = '0;
    req_we        = '0;
    req_wdata     = '0;
    req_wstrb     = 8'hFF;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    set_req(0, 32'h1000, 1'b0, 32'h0);
    set_req(1, 32'h2000, 1'b0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_proto_err", 64'(proto_err), 64'd0);
    end

    // Contention: req1 promoted after four denied cycles, responses one cycle later.
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 0) rst_n = 1'b1;
      req_valid     = (k < 6) ? 2'b11 : 2'b00;
      mem_rsp_valid = (k >= 1);
      mem_rsp_rdata = 32'hD000 + 32'(k);
      if (k < 6) exp_iss(2'(1 << gexp[k]), (gexp[k] == 1) ? 32'h2000 : 32'h1000, 1'b0, 32'h0);
      if (k >= 1) exp_rsp(2'(1 << gexp[k-1]), 32'hD000 + 32'(k), 1'b0);
      @(negedge clk);
      if (k < 6) check("starve_grant", 64'(req_ready), 64'(1 << gexp[k]));
    end

    // Lock: req1 stalls, req0 arrives mid-stall, grant and payload must hold.
    cyc();
    req_valid     = 2'b10;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    set_req(1, 32'h2000, 1'b1, 32'h55AA);
    @(negedge clk);
    check("lock_valid", 64'(mem_req_valid), 64'd1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      req_valid = 2'b11;
      @(negedge clk);
      check("lock_addr", 64'(mem_req_addr), 64'h2000);
      check("lock_we", 64'(mem_req_we), 64'd1);
      check("lock_ready", 64'(req_ready), 64'd0);
    end
    cyc();
    mem_req_ready = 1'b1;
    exp_iss(2'b10, 32'h2000, 1'b1, 32'h55AA);
    @(negedge clk);
    check("lock_release_wdata", 64'(mem_req_wdata), 64'h55AA);
    cyc();
    req_valid = 2'b01;
    exp_iss(2'b01, 32'h1000, 1'b0, 32'h0);
    cyc();
    req_valid     = 2'b00;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1111;
    exp_rsp(2'b10, 32'h1111, 1'b0);
    cyc();
    mem_rsp_rdata = 32'h2222;
    exp_rsp(2'b01, 32'h2222, 1'b0);
    cyc();
    mem_rsp_valid = 1'b0;

    // Full: two loads outstanding block further issue, even on a same-cycle response.
    cyc();
    req_valid = 2'b01;
    set_req(0, 32'h100, 1'b0, 32'h0);
    set_req(1, 32'h200, 1'b0, 32'h0);
    exp_iss(2'b01, 32'h100, 1'b0, 32'h0);
    cyc();
    req_valid = 2'b10;
    exp_iss(2'b10, 32'h200, 1'b0, 32'h0);
    cyc();
    req_valid = 2'b11;
    @(negedge clk);
    check("full_no_issue", 64'(mem_req_valid), 64'd0);
    check("full_no_ready", 64'(req_ready), 64'd0);
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hAAAA;
    exp_rsp(2'b01, 32'hAAAA, 1'b0);
    @(negedge clk);
    check("full_registered", 64'(mem_req_valid), 64'd0);
    cyc();
    req_valid     = 2'b00;
    mem_rsp_rdata = 32'hBBBB;
    mem_rsp_err   = 1'b1;
    exp_rsp(2'b10, 32'hBBBB, 1'b1);
    cyc();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;

    // Stray response with nothing outstanding.
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD;
    @(negedge clk);
    check("stray_no_rsp", 64'(rsp_valid), 64'd0);
    check("stray_err_pre", 64'(proto_err), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check("stray_err_sticky", 64'(proto_err), 64'd1);
    end
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("stray_err_cleared", 64'(proto_err), 64'd0);

    // Reset with one request outstanding, then the stale response shows up.
    cyc();
    rst_n     = 1'b1;
    req_valid = 2'b01;
    set_req(0, 32'h300, 1'b0, 32'h0);
    exp_iss(2'b01, 32'h300, 1'b0, 32'h0);
    @(negedge clk);
    check("stale_issue_ready", 64'(req_ready), 64'd1);
    cyc();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    @(negedge clk);
    check("stale_rst_err", 64'(proto_err), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5757;
    @(negedge clk);
    check("stale_no_rsp", 64'(rsp_valid), 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stale_proto_err", 64'(proto_err), 64'd1);

    repeat (2) @(negedge clk);
    check("iss_q_drained", 64'(iss_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
